// File: rtl/res_st_array_pkg.sv
// Shared types and sizing for the reservation-station array.
// Tags encode operand readiness: 0 = ready, otherwise producing ROB address + 1.
package res_st_array_pkg;

  localparam int RES_ST_NUM_ENTRIES = 8;
  localparam int RES_ST_ADDR_W      = $clog2(RES_ST_NUM_ENTRIES);
  localparam int ROB_ADDR_W         = 4;
  localparam int RES_ST_TAG_W       = ROB_ADDR_W + 1;
  localparam int PHY_RF_DATA_W      = 32;

  typedef logic [RES_ST_ADDR_W-1:0] res_st_addr_t;
  typedef logic [ROB_ADDR_W-1:0]    rob_addr_t;
  typedef logic [RES_ST_TAG_W-1:0]  res_st_tag_t;
  typedef logic [PHY_RF_DATA_W-1:0] phy_rf_data_t;
  typedef logic [3:0]               res_st_op_t;

  typedef struct packed {
    logic         busy;
    res_st_op_t   op;
    rob_addr_t    rob_addr;
    res_st_tag_t  qj;
    res_st_tag_t  qk;
    phy_rf_data_t vj;
    phy_rf_data_t vk;
  } res_st_cell_t;

  // One extra tag bit keeps ROB address 15 distinct from "ready".
  function automatic res_st_tag_t rob_to_tag(input rob_addr_t addr);
    return res_st_tag_t'({1'b0, addr}) + res_st_tag_t'(1);
  endfunction

endpackage

// File: rtl/res_st_array_if.sv
// Bus bundle for res_st_array: dispatch, read/issue ports, result broadcast, status.
interface res_st_array_if import res_st_array_pkg::*; #(
  parameter int NUM_ENTRIES = RES_ST_NUM_ENTRIES
) ();

  localparam int CW = $clog2(NUM_ENTRIES) + 1;

  logic                   disp_valid;
  res_st_cell_t           disp_cell;
  logic                   disp_ready;
  res_st_addr_t           res_st_rd1_addr;
  res_st_addr_t           res_st_rd2_addr;
  res_st_addr_t           res_st_rd3_addr;
  res_st_addr_t           res_st_rd4_addr;
  res_st_cell_t           res_st_rd1_out;
  res_st_cell_t           res_st_rd2_out;
  res_st_cell_t           res_st_rd3_out;
  res_st_cell_t           res_st_rd4_out;
  logic [3:0]             issue_en;
  logic                   res_st_retire_en;
  rob_addr_t              res_st_retire_rob_addr;
  phy_rf_data_t           res_st_retire_value;
  logic                   flush;
  logic [NUM_ENTRIES-1:0] ready_vec;
  logic [CW-1:0]          res_st_count;
  logic                   res_st_full;

  modport slave (
    input  disp_valid, disp_cell,
    output disp_ready,
    input  res_st_rd1_addr, res_st_rd2_addr, res_st_rd3_addr, res_st_rd4_addr,
    output res_st_rd1_out, res_st_rd2_out, res_st_rd3_out, res_st_rd4_out,
    input  issue_en, res_st_retire_en, res_st_retire_rob_addr, res_st_retire_value, flush,
    output ready_vec, res_st_count, res_st_full
  );

  modport master (
    output disp_valid, disp_cell,
    input  disp_ready,
    output res_st_rd1_addr, res_st_rd2_addr, res_st_rd3_addr, res_st_rd4_addr,
    input  res_st_rd1_out, res_st_rd2_out, res_st_rd3_out, res_st_rd4_out,
    output issue_en, res_st_retire_en, res_st_retire_rob_addr, res_st_retire_value, flush,
    input  ready_vec, res_st_count, res_st_full
  );

endinterface

// File: rtl/res_st_array_alloc.sv
// Lowest-index free-entry picker for the reservation-station array.
module res_st_alloc #(
  parameter  int NUM_ENTRIES = 8,
  localparam int AW          = $clog2(NUM_ENTRIES)
) (
  input  logic [NUM_ENTRIES-1:0] i_busy,
  output logic                   o_free_valid,
  output logic [AW-1:0]          o_free_idx
);

  // Scan upward; the first free slot found wins.
  always_comb begin
    o_free_valid = 1'b0;
    o_free_idx   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!i_busy[i] && !o_free_valid) begin
        o_free_valid = 1'b1;
        o_free_idx   = AW'(i);
      end else begin
        o_free_idx   = o_free_idx;
      end
    end
  end

endmodule

// File: rtl/res_st_array.sv
// Reservation-station array: dispatch into lowest free entry, 4 read/issue ports, tag wakeup.
// Optional RES_ST_DISPATCH_BYPASS_EN captures a same-cycle broadcast into the dispatched entry.
module res_st_array import res_st_array_pkg::*; #(
  parameter int NUM_ENTRIES = RES_ST_NUM_ENTRIES
) (
  input  logic          clk,
  input  logic          rst,
  res_st_array_if.slave bus
);

  localparam int CW = $clog2(NUM_ENTRIES) + 1;
  localparam int AW = $clog2(NUM_ENTRIES);

  res_st_cell_t           r_entries     [NUM_ENTRIES];
  res_st_cell_t           w_entries_nxt [NUM_ENTRIES];
  logic [CW-1:0]          r_count;
  logic [CW-1:0]          w_count_nxt;
  logic                   r_full;
  logic [NUM_ENTRIES-1:0] w_busy;
  logic [NUM_ENTRIES-1:0] w_ready_vec;
  logic                   w_free_valid;
  logic [AW-1:0]          w_free_idx;
  logic                   w_disp_ready;
  logic                   w_disp_fire;
  res_st_cell_t           w_disp_cell;
  res_st_tag_t            w_ret_tag;
  res_st_addr_t           w_rd_addr     [4];

  assign w_rd_addr[0] = bus.res_st_rd1_addr;
  assign w_rd_addr[1] = bus.res_st_rd2_addr;
  assign w_rd_addr[2] = bus.res_st_rd3_addr;
  assign w_rd_addr[3] = bus.res_st_rd4_addr;
  assign w_ret_tag    = rob_to_tag(bus.res_st_retire_rob_addr);

`ifdef RES_ST_DISPATCH_BYPASS_EN
  assign w_disp_ready = rst & ~r_full & ~bus.flush;
`else
  // Without bypass a dispatch could miss a broadcast landing in the same cycle.
  assign w_disp_ready = rst & ~r_full & ~bus.flush & ~bus.res_st_retire_en;
`endif
  assign w_disp_fire  = bus.disp_valid & w_disp_ready & w_free_valid;

  // Busy and ready views of the registered entries.
  always_comb begin
    w_busy      = '0;
    w_ready_vec = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_busy[i]      = r_entries[i].busy;
      w_ready_vec[i] = r_entries[i].busy && (r_entries[i].qj == '0) && (r_entries[i].qk == '0);
    end
  end

  res_st_alloc #(.NUM_ENTRIES(NUM_ENTRIES)) u_alloc (
    .i_busy       (w_busy),
    .o_free_valid (w_free_valid),
    .o_free_idx   (w_free_idx)
  );

  // Dispatched cell, optionally absorbing the broadcast seen this cycle.
  always_comb begin
    w_disp_cell      = bus.disp_cell;
    w_disp_cell.busy = 1'b1;
`ifdef RES_ST_DISPATCH_BYPASS_EN
    if (bus.res_st_retire_en && (w_disp_cell.qj == w_ret_tag)) begin
      w_disp_cell.vj = bus.res_st_retire_value;
      w_disp_cell.qj = '0;
    end else begin
      w_disp_cell.qj = w_disp_cell.qj;
    end
    if (bus.res_st_retire_en && (w_disp_cell.qk == w_ret_tag)) begin
      w_disp_cell.vk = bus.res_st_retire_value;
      w_disp_cell.qk = '0;
    end else begin
      w_disp_cell.qk = w_disp_cell.qk;
    end
`endif
  end

  // Next-state entries: flush overrides issue, wakeup and dispatch.
  always_comb begin
    w_entries_nxt = r_entries;
    if (bus.flush) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        w_entries_nxt[i].busy = 1'b0;
      end
    end else begin
      for (int p = 0; p < 4; p++) begin
        if (bus.issue_en[p]) begin
          w_entries_nxt[w_rd_addr[p]].busy = 1'b0;
        end else begin
          w_entries_nxt[w_rd_addr[p]].busy = w_entries_nxt[w_rd_addr[p]].busy;
        end
      end
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (bus.res_st_retire_en && r_entries[i].busy && (r_entries[i].qj == w_ret_tag)) begin
          w_entries_nxt[i].vj = bus.res_st_retire_value;
          w_entries_nxt[i].qj = '0;
        end else begin
          w_entries_nxt[i].qj = w_entries_nxt[i].qj;
        end
        if (bus.res_st_retire_en && r_entries[i].busy && (r_entries[i].qk == w_ret_tag)) begin
          w_entries_nxt[i].vk = bus.res_st_retire_value;
          w_entries_nxt[i].qk = '0;
        end else begin
          w_entries_nxt[i].qk = w_entries_nxt[i].qk;
        end
      end
      // Target is free in registered state, so a stale issue to it cannot clear the new entry.
      if (w_disp_fire) begin
        w_entries_nxt[w_free_idx] = w_disp_cell;
      end else begin
        w_entries_nxt[w_free_idx] = w_entries_nxt[w_free_idx];
      end
    end
  end

  // Occupancy of the next state, so count/full track busy after every edge.
  always_comb begin
    w_count_nxt = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_count_nxt = w_count_nxt + CW'(w_entries_nxt[i].busy);
    end
  end

  // Entry storage and registered status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_entries[i] <= '0;
      end
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      r_entries <= w_entries_nxt;
      r_count   <= w_count_nxt;
      r_full    <= (w_count_nxt == CW'(NUM_ENTRIES));
    end
  end

  assign bus.disp_ready     = w_disp_ready;
  assign bus.res_st_rd1_out = r_entries[w_rd_addr[0]];
  assign bus.res_st_rd2_out = r_entries[w_rd_addr[1]];
  assign bus.res_st_rd3_out = r_entries[w_rd_addr[2]];
  assign bus.res_st_rd4_out = r_entries[w_rd_addr[3]];
  assign bus.ready_vec      = w_ready_vec;
  assign bus.res_st_count   = r_count;
  assign bus.res_st_full    = r_full;

endmodule

// File: tb/tb_res_st_array.sv
// Self-checking bench for res_st_array: directed scenarios plus randomized traffic vs a reference model.
module tb_res_st_array;
  import res_st_array_pkg::*;

  localparam int N = RES_ST_NUM_ENTRIES;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  res_st_array_if #(.NUM_ENTRIES(N)) bus ();
  res_st_array #(.NUM_ENTRIES(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  res_st_cell_t m_cell [N];
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_cell[i].busy);
    return c;
  endfunction

  function automatic logic exp_disp_ready();
`ifdef RES_ST_DISPATCH_BYPASS_EN
    return rst && (m_count() < N) && !bus.flush;
`else
    return rst && (m_count() < N) && !bus.flush && !bus.res_st_retire_en;
`endif
  endfunction

  function automatic res_st_cell_t mk_cell(input int op, input int rob, input int qj, input int qk,
                                           input logic [31:0] vj, input logic [31:0] vk);
    res_st_cell_t c;
    c.busy = 1'b0; c.op = 4'(op); c.rob_addr = 4'(rob);
    c.qj = 5'(qj); c.qk = 5'(qk); c.vj = vj; c.vk = vk;
    return c;
  endfunction

  task automatic compare_all();
    logic [N-1:0] rv;
    for (int i = 0; i < N; i++) rv[i] = m_cell[i].busy && (m_cell[i].qj == 5'd0) && (m_cell[i].qk == 5'd0);
    chk("disp_ready", 128'(bus.disp_ready), 128'(exp_disp_ready()));
    chk("count", 128'(bus.res_st_count), 128'(m_count()));
    chk("full", 128'(bus.res_st_full), 128'(m_count() == N));
    chk("ready_vec", 128'(bus.ready_vec), 128'(rv));
    chk("rd1_out", 128'(bus.res_st_rd1_out), 128'(m_cell[bus.res_st_rd1_addr]));
    chk("rd2_out", 128'(bus.res_st_rd2_out), 128'(m_cell[bus.res_st_rd2_addr]));
    chk("rd3_out", 128'(bus.res_st_rd3_out), 128'(m_cell[bus.res_st_rd3_addr]));
    chk("rd4_out", 128'(bus.res_st_rd4_out), 128'(m_cell[bus.res_st_rd4_addr]));
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cell[i] = '0;
  endtask

  // Apply one clock edge's worth of rules to the model, using inputs held over the cycle.
  task automatic model_edge();
    res_st_cell_t nxt [N];
    res_st_cell_t c;
    int slot, tag;
    int addrs [4];
    logic accept;
    if (!rst) begin
      model_reset();
      return;
    end
    if (bus.flush) begin
      for (int i = 0; i < N; i++) m_cell[i].busy = 1'b0;
      return;
    end
    nxt = m_cell;
    accept = bus.disp_valid && exp_disp_ready();
    slot = -1;
    for (int i = N - 1; i >= 0; i--) if (!m_cell[i].busy) slot = i;
    addrs[0] = int'(bus.res_st_rd1_addr); addrs[1] = int'(bus.res_st_rd2_addr);
    addrs[2] = int'(bus.res_st_rd3_addr); addrs[3] = int'(bus.res_st_rd4_addr);
    for (int p = 0; p < 4; p++) if (bus.issue_en[p]) nxt[addrs[p]].busy = 1'b0;
    tag = int'(bus.res_st_retire_rob_addr) + 1;
    if (bus.res_st_retire_en) begin
      for (int i = 0; i < N; i++) begin
        if (m_cell[i].busy && int'(m_cell[i].qj) == tag) begin nxt[i].qj = 5'd0; nxt[i].vj = bus.res_st_retire_value; end
        if (m_cell[i].busy && int'(m_cell[i].qk) == tag) begin nxt[i].qk = 5'd0; nxt[i].vk = bus.res_st_retire_value; end
      end
    end
    if (accept && slot >= 0) begin
      c = bus.disp_cell;
      c.busy = 1'b1;
`ifdef RES_ST_DISPATCH_BYPASS_EN
      if (bus.res_st_retire_en && int'(c.qj) == tag) begin c.qj = 5'd0; c.vj = bus.res_st_retire_value; end
      if (bus.res_st_retire_en && int'(c.qk) == tag) begin c.qk = 5'd0; c.vk = bus.res_st_retire_value; end
`endif
      nxt[slot] = c;
    end
    m_cell = nxt;
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    bus.disp_valid = 1'b0; bus.disp_cell = '0;
    bus.res_st_rd1_addr = 3'd0; bus.res_st_rd2_addr = 3'd0;
    bus.res_st_rd3_addr = 3'd0; bus.res_st_rd4_addr = 3'd0;
    bus.issue_en = 4'b0000; bus.res_st_retire_en = 1'b0;
    bus.res_st_retire_rob_addr = 4'd0; bus.res_st_retire_value = 32'd0;
    bus.flush = 1'b0;
  endtask

  task automatic fill_array();
    for (int k = 0; k < N; k++) begin
      bus.disp_valid = 1'b1;
      bus.disp_cell  = mk_cell(k, k, 0, 0, $urandom, $urandom);
      step();
    end
    idle_inputs();
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    step();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    #1 rst = 1'b0;
    step();
    step();
    chk("disp_ready_in_reset", 128'(bus.disp_ready), 128'(0));
    rst = 1'b1;
    #1;
    chk("rst_count", 128'(bus.res_st_count), 128'(0));
    chk("rst_full", 128'(bus.res_st_full), 128'(0));
    chk("rst_ready_vec", 128'(bus.ready_vec), 128'(0));
    chk("rst_release_disp_ready", 128'(bus.disp_ready), 128'(1));

    // Fill all entries with ready operands.
    fill_array();
    #1;
    chk("fill_count", 128'(bus.res_st_count), 128'(8));
    chk("fill_full", 128'(bus.res_st_full), 128'(1));
    chk("fill_disp_ready", 128'(bus.disp_ready), 128'(0));
    chk("fill_ready_vec", 128'(bus.ready_vec), 128'(8'hFF));
    chk("model_fill_count", 128'(m_count()), 128'(8));

    // Flush beats a simultaneous dispatch.
    bus.flush = 1'b1;
    bus.disp_valid = 1'b1;
    bus.disp_cell = mk_cell(5, 5, 0, 0, 32'h1, 32'h2);
    step();
    idle_inputs();
    #1;
    chk("flush_count", 128'(bus.res_st_count), 128'(0));
    chk("flush_ready_vec", 128'(bus.ready_vec), 128'(0));
    chk("flush_rd1_busy", 128'(bus.res_st_rd1_out.busy), 128'(0));

    // Wakeup of qj by ROB 1.
    bus.disp_valid = 1'b1;
    bus.disp_cell = mk_cell(1, 7, 2, 0, 32'h0, 32'h9);
    step();
    idle_inputs();
    #1;
    chk("wait_ready_vec", 128'(bus.ready_vec), 128'(0));
    bus.res_st_retire_en = 1'b1;
    bus.res_st_retire_rob_addr = 4'd1;
    bus.res_st_retire_value = 32'h55;
    step();
    idle_inputs();
    #1;
    chk("wake_vj", 128'(bus.res_st_rd1_out.vj), 128'(32'h55));
    chk("wake_qj", 128'(bus.res_st_rd1_out.qj), 128'(0));
    chk("wake_ready_vec", 128'(bus.ready_vec), 128'(8'h01));

    // Dispatch racing a broadcast for ROB 2.
    bus.disp_valid = 1'b1;
    bus.disp_cell = mk_cell(2, 8, 0, 3, 32'h3, 32'h0);
    bus.res_st_retire_en = 1'b1;
    bus.res_st_retire_rob_addr = 4'd2;
    bus.res_st_retire_value = 32'h77;
    #1;
`ifdef RES_ST_DISPATCH_BYPASS_EN
    chk("race_disp_ready", 128'(bus.disp_ready), 128'(1));
    step();
    idle_inputs();
    bus.res_st_rd1_addr = 3'd1;
    #1;
    chk("race_vk", 128'(bus.res_st_rd1_out.vk), 128'(32'h77));
    chk("race_qk", 128'(bus.res_st_rd1_out.qk), 128'(0));
    chk("race_ready_vec", 128'(bus.ready_vec), 128'(8'h03));
`else
    chk("race_disp_ready", 128'(bus.disp_ready), 128'(0));
    step();
    bus.res_st_retire_en = 1'b0;
    step();
    idle_inputs();
    bus.res_st_rd1_addr = 3'd1;
    #1;
    chk("race_busy", 128'(bus.res_st_rd1_out.busy), 128'(1));
    chk("race_qk", 128'(bus.res_st_rd1_out.qk), 128'(3));
    chk("race_ready_vec", 128'(bus.ready_vec), 128'(8'h01));
`endif

    // Full array: issue entry 3 via port 2 while dispatch waits.
    do_flush();
    fill_array();
    bus.disp_valid = 1'b1;
    bus.disp_cell = mk_cell(10, 3, 0, 0, 32'hA, 32'hB);
    bus.issue_en = 4'b0010;
    bus.res_st_rd2_addr = 3'd3;
    #1;
    chk("issue_full_disp_ready", 128'(bus.disp_ready), 128'(0));
    step();
    bus.issue_en = 4'b0000;
    #1;
    chk("issue_count", 128'(bus.res_st_count), 128'(7));
    chk("issue_rd2_busy", 128'(bus.res_st_rd2_out.busy), 128'(0));
    chk("issue_full", 128'(bus.res_st_full), 128'(0));
    step();
    bus.disp_valid = 1'b0;
    #1;
    chk("refill_count", 128'(bus.res_st_count), 128'(8));
    chk("refill_rd2_busy", 128'(bus.res_st_rd2_out.busy), 128'(1));
    chk("refill_rd2_op", 128'(bus.res_st_rd2_out.op), 128'(4'hA));

    // Reset mid-cycle with 5 entries busy and a dispatch pending.
    do_flush();
    for (int k = 0; k < 5; k++) begin
      bus.disp_valid = 1'b1;
      bus.disp_cell = mk_cell(k, k, 0, 0, 32'(k + 1), 32'(k + 2));
      step();
    end
    bus.disp_cell = mk_cell(9, 9, 0, 0, 32'hF, 32'hF);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("midrst_count", 128'(bus.res_st_count), 128'(0));
    chk("midrst_full", 128'(bus.res_st_full), 128'(0));
    chk("midrst_ready_vec", 128'(bus.ready_vec), 128'(0));
    chk("midrst_disp_ready", 128'(bus.disp_ready), 128'(0));
    chk("midrst_rd1", 128'(bus.res_st_rd1_out), 128'(0));
    step();
    idle_inputs();
    rst = 1'b1;

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.disp_valid = ($urandom_range(0, 9) < 6);
      bus.disp_cell = mk_cell($urandom_range(0, 15), $urandom_range(0, 15),
                              $urandom_range(0, 1) ? 0 : $urandom_range(1, 4),
                              $urandom_range(0, 1) ? 0 : $urandom_range(1, 4),
                              $urandom, $urandom);
      bus.disp_cell.busy = 1'($urandom_range(0, 1));
      bus.res_st_rd1_addr = 3'($urandom_range(0, 7));
      bus.res_st_rd2_addr = 3'($urandom_range(0, 7));
      bus.res_st_rd3_addr = 3'($urandom_range(0, 7));
      bus.res_st_rd4_addr = 3'($urandom_range(0, 7));
      for (int p = 0; p < 4; p++) bus.issue_en[p] = ($urandom_range(0, 3) == 0);
      bus.res_st_retire_en = ($urandom_range(0, 9) < 3);
      bus.res_st_retire_rob_addr = 4'($urandom_range(0, 3));
      bus.res_st_retire_value = $urandom;
      bus.flush = ($urandom_range(0, 63) == 0);
      step();
    end
    idle_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/res_st_array.md
RES_ST_ARRAY -- requirements
Module: res_st_array

Interface
REQ-001 SHALL have parameter: NUM_ENTRIES, RES_ST_NUM_ENTRIES (8), reservation-station depth, power of two.
REQ-002 SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
REQ-003 SHALL have the following ports:
- disp_valid  in  1  dispatch request.
- disp_cell  in  res_st_cell_t  entry to allocate.
- disp_ready  out  1  dispatch accepted when high.
- res_st_rd1_addr..res_st_rd4_addr  in  res_st_addr_t  read-port addresses.
- res_st_rd1_out..res_st_rd4_out  out  res_st_cell_t  read-port data.
- issue_en  in  4  bit i frees the entry addressed by read port i+1.
- res_st_retire_en  in  1  result broadcast valid.
- res_st_retire_rob_addr  in  rob_addr_t  producing ROB entry.
- res_st_retire_value  in  phy_rf_data_t  broadcast value.
- flush  in  1  discard all entries.
- ready_vec  out  NUM_ENTRIES  entry busy with both operands ready.
- res_st_count  out  $clog2(NUM_ENTRIES)+1  occupied entries.
- res_st_full  out  1  no free entry.

Function
REQ-004 SHALL encode operand tags qj/qk (res_st_tag_t) as 0 = operand ready, nonzero = producing ROB address + 1.
REQ-005 SHALL hold disp_ready = !res_st_full & !flush, combinationally.
REQ-006 SHALL, on disp_valid & disp_ready at a rising edge, write disp_cell into the lowest-index non-busy entry with busy=1.
REQ-007 SHALL base allocation on busy bits registered at the start of the cycle; an entry freed by issue_en becomes allocatable one cycle later.
REQ-008 SHALL drive res_st_rdN_out combinationally from entry[res_st_rdN_addr], with zero latency.
REQ-009 SHALL clear busy of each entry addressed by an asserted issue_en bit at the next edge; duplicate addresses across ports SHALL free the entry once, without error.
REQ-010 SHALL, on res_st_retire_en, set vj=value and qj=0 in every busy entry with qj == res_st_retire_rob_addr+1 at the next edge; likewise vk/qk.
REQ-011 SHALL let qj and qk of the same entry both match and both update in one cycle.
REQ-012 SHALL compute ready_vec[i] = busy & qj==0 & qk==0 combinationally from registered state.
REQ-013 SHALL keep res_st_count and res_st_full registered, consistent with busy bits after every edge, including simultaneous dispatch and issue.
REQ-014 SHALL, on flush, clear all busy bits at the next edge; flush has priority over dispatch, issue and wakeup.
REQ-015 SHALL ignore issue_en addressing a non-busy entry.

Reset
REQ-016 SHALL, while rst=0, immediately clear all entries to zero, res_st_count=0, res_st_full=0, ready_vec=0.
REQ-017 SHALL, while rst=0, hold disp_ready=0; after release, disp_ready=1 with no cycle of delay.
REQ-018 SHALL drop any dispatch or wakeup in flight when reset asserts mid-cycle.

Configuration
REQ-019 SHALL, with RES_ST_DISPATCH_BYPASS_EN defined, capture a retire broadcast matching disp_cell's qj/qk into the newly written entry in the same cycle (value stored, tag zeroed).
REQ-020 SHALL, without RES_ST_DISPATCH_BYPASS_EN, deassert disp_ready whenever res_st_retire_en=1, so no broadcast is missed.

Structure
REQ-021 SHALL place the following in the shared Qu package: res_st_cell_t, res_st_addr_t, res_st_tag_t, rob_addr_t, phy_rf_data_t and RES_ST_NUM_ENTRIES.
REQ-022 SHALL implement lowest-free-index selection as one sub-module, res_st_alloc.

Verification
REQ-023 SHALL cover:
- Reset, then 8 dispatches with qj=qk=0 -> count=8, full=1, disp_ready=0, ready_vec=8'hFF.
- Dispatch with qj=2, then retire rob_addr=1, value=32'h55 -> vj=32'h55, qj=0 next edge; ready bit set.
- Dispatch with qk=3 in the same cycle as retire rob_addr=2 -> with macro, vk captured; without, disp_ready=0 and accepted next cycle.
- Full array, issue_en=4'b0010 with rd2_addr=3, disp_valid=1 -> entry 3 freed next edge, dispatch lands in entry 3 one cycle later.
- flush=1 together with disp_valid=1 -> count=0, ready_vec=0, dispatched cell discarded.
- rst asserted between edges with 5 entries busy -> all outputs zero before the next clk edge.
